audio_tone_scheduler: RTL and testbench



---
 rtl/audio_pkg.sv | 24 ++
 rtl/audio_tone_scheduler_tone_gen.sv | 46 ++++
 rtl/audio_tone_scheduler.sv | 172 +++++++++++++++++
 tb/tb_audio_tone_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio tone scheduler and its tone generator.
package audio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAKE  = 3'd1,
    ST_BEEP  = 3'd2,
    ST_ALARM = 3'd3,
    ST_PASS  = 3'd4
  } state_t;

  localparam int DUTY_W = 10;
  localparam int CNT_W  = 24;
  localparam logic [DUTY_W-1:0] BEEP_LEVEL_DEF = 10'd512;

  // Target selection once the amplifier is awake: alarm beats beep beats passthrough.
  function automatic state_t pick_target(input logic alarm, input logic beat, input logic pass);
    if (alarm) return ST_ALARM;
    if (beat)  return ST_BEEP;
    if (pass)  return ST_PASS;
    return ST_IDLE;
  endfunction

endpackage

// File: rtl/audio_tone_scheduler_tone_gen.sv
// Square-wave phase generator: level toggles every half_period cycles while enabled,
// restarting in the high phase whenever enable rises.
module tone_gen
  import audio_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] half_period,
  output logic             level,
  output logic             phase_end
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             enable_d_reg;
  logic             level_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_d_reg <= 1'b0;
      level_reg    <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      enable_d_reg <= enable;
      if (!enable) begin
        level_reg <= 1'b0;
        cnt_reg   <= '0;
      end else if (!enable_d_reg) begin
        level_reg <= 1'b1;
        cnt_reg   <= half_period;
      end else if (cnt_reg == CNT_ONE) begin
        // half_period is sampled only here, so a new period starts on a phase boundary
        level_reg <= ~level_reg;
        cnt_reg   <= half_period;
      end else begin
        cnt_reg <= cnt_reg - CNT_ONE;
      end
    end
  end

  assign level     = level_reg;
  assign phase_end = (cnt_reg == CNT_ONE);

endmodule

// File: rtl/audio_tone_scheduler.sv
// Arbitrates heartbeat beeps, alarm tone and ADC passthrough onto one PWM stage + amplifier.
// The alarm tone path is built only when AUDIO_ALARM_EN is defined.
module audio_tone_scheduler
  import audio_pkg::*;
#(
  parameter int unsigned       TONE_HALF    = 50000,
  parameter int unsigned       BEEP_LEN     = 5000000,
  parameter int unsigned       WAKE_LEN     = 1000,
  parameter int unsigned       ALARM_HALF_A = 25000,
  parameter int unsigned       ALARM_HALF_B = 40000,
  parameter int unsigned       ALARM_SWITCH = 10000000,
  parameter logic [DUTY_W-1:0] BEEP_LEVEL   = BEEP_LEVEL_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              beat_pulse,
  input  logic              alarm_req,
  input  logic              pass_en,
  input  logic [DUTY_W-1:0] adc_measure,
  input  logic              adc_valid,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              output_enable,
  output logic              pwm_sd,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TONE_HALF_C = CNT_W'(TONE_HALF);
  localparam logic [CNT_W-1:0] BEEP_LEN_C  = CNT_W'(BEEP_LEN);
  localparam logic [CNT_W-1:0] WAKE_LEN_C  = CNT_W'(WAKE_LEN);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              pend_beat_reg;
  logic [DUTY_W-1:0] pass_sample_reg;
  logic [DUTY_W-1:0] duty_cycle_reg;
  logic              output_enable_reg, pwm_sd_reg, busy_reg;

  logic              alarm_act;
  logic              tone_en, tone_level, tone_phase_end;
  logic [CNT_W-1:0]  tone_half;

`ifdef AUDIO_ALARM_EN
  localparam logic [CNT_W-1:0] HALF_A_C = CNT_W'(ALARM_HALF_A);
  localparam logic [CNT_W-1:0] HALF_B_C = CNT_W'(ALARM_HALF_B);
  localparam logic [CNT_W-1:0] SWITCH_C = CNT_W'(ALARM_SWITCH);

  logic             alarm_b_reg;
  logic [CNT_W-1:0] alarm_sw_cnt_reg;

  assign alarm_act = alarm_req;
  assign tone_half = (state_next == ST_ALARM) ? (alarm_b_reg ? HALF_B_C : HALF_A_C) : TONE_HALF_C;

  // Counting starts on the entry edge so the A/B swap lands on a tone reload boundary.
  always_ff @(posedge clk) begin
    if (reset || state_next != ST_ALARM) begin
      alarm_b_reg      <= 1'b0;
      alarm_sw_cnt_reg <= SWITCH_C;
    end else if (alarm_sw_cnt_reg == CNT_ONE) begin
      alarm_b_reg      <= ~alarm_b_reg;
      alarm_sw_cnt_reg <= SWITCH_C;
    end else begin
      alarm_sw_cnt_reg <= alarm_sw_cnt_reg - CNT_ONE;
    end
  end
`else
  logic unused_alarm;
  assign unused_alarm = alarm_req ^ tone_phase_end ^ (ALARM_HALF_A == 0)
                      ^ (ALARM_HALF_B == 0) ^ (ALARM_SWITCH == 0);
  assign alarm_act = 1'b0;
  assign tone_half = TONE_HALF_C;
`endif

  // The generator follows the next state so its phase is aligned with the registered outputs.
  assign tone_en = (state_next == ST_BEEP) || (state_next == ST_ALARM);

  tone_gen u_tone_gen (
    .clk         (clk),
    .reset       (reset),
    .enable      (tone_en),
    .half_period (tone_half),
    .level       (tone_level),
    .phase_end   (tone_phase_end)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (alarm_act || beat_pulse || pass_en) state_next = ST_WAKE;
      end
      ST_WAKE: begin
        if (cnt_reg == CNT_ONE)
          state_next = pick_target(alarm_act, pend_beat_reg | beat_pulse, pass_en);
      end
      ST_BEEP: begin
        if (!beat_pulse && cnt_reg == CNT_ONE)
          state_next = pick_target(alarm_act, 1'b0, pass_en);
      end
`ifdef AUDIO_ALARM_EN
      ST_ALARM: begin
        if (!alarm_act && tone_phase_end) state_next = pass_en ? ST_PASS : ST_IDLE;
      end
`endif
      ST_PASS: begin
        if (alarm_act)       state_next = ST_ALARM;
        else if (beat_pulse) state_next = ST_BEEP;
        else if (!pass_en)   state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      cnt_reg           <= '0;
      pend_beat_reg     <= 1'b0;
      pass_sample_reg   <= '0;
      duty_cycle_reg    <= '0;
      output_enable_reg <= 1'b0;
      pwm_sd_reg        <= 1'b0;
      busy_reg          <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (state_next == ST_WAKE && state_reg != ST_WAKE)
        cnt_reg <= WAKE_LEN_C;
      else if (state_next == ST_BEEP && (state_reg != ST_BEEP || beat_pulse))
        cnt_reg <= BEEP_LEN_C;
      else if (cnt_reg != '0)
        cnt_reg <= cnt_reg - CNT_ONE;

      // A beat coinciding with an alarm request is dropped.
      if (state_next == ST_WAKE) pend_beat_reg <= pend_beat_reg | (beat_pulse & ~alarm_act);
      else                       pend_beat_reg <= 1'b0;

      if (state_reg == ST_PASS && adc_valid) pass_sample_reg <= adc_measure;
      else if (state_reg == ST_IDLE)         pass_sample_reg <= '0;

      busy_reg <= (state_reg != ST_IDLE);
      case (state_reg)
        ST_WAKE: begin
          pwm_sd_reg        <= 1'b1;
          output_enable_reg <= 1'b0;
          duty_cycle_reg    <= '0;
        end
        ST_BEEP, ST_ALARM: begin
          pwm_sd_reg        <= 1'b1;
          output_enable_reg <= 1'b1;
          duty_cycle_reg    <= tone_level ? BEEP_LEVEL : '0;
        end
        ST_PASS: begin
          pwm_sd_reg        <= 1'b1;
          output_enable_reg <= 1'b1;
          duty_cycle_reg    <= adc_valid ? adc_measure : pass_sample_reg;
        end
        default: begin
          pwm_sd_reg        <= 1'b0;
          output_enable_reg <= 1'b0;
          duty_cycle_reg    <= '0;
        end
      endcase
    end
  end

  assign duty_cycle    = duty_cycle_reg;
  assign output_enable = output_enable_reg;
  assign pwm_sd        = pwm_sd_reg;
  assign busy          = busy_reg;

endmodule

// File: tb/tb_audio_tone_scheduler.sv
// Directed bench for audio_tone_scheduler using shortened timing parameters.
module tb_audio_tone_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       beat_pulse = 1'b0;
  logic       alarm_req = 1'b0;
  logic       pass_en = 1'b0;
  logic       adc_valid = 1'b0;
  logic [9:0] adc_measure = 10'd0;
  logic [9:0] duty_cycle;
  logic       output_enable, pwm_sd, busy;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef AUDIO_ALARM_EN
  int         runs [14] = '{3, 3, 3, 3, 3, 3, 3, 3, 6, 6, 6, 6, 3, 3};
  logic [53:0] alarm_lvl;
  int         pos;
  logic       cur;
`endif

  always #5 clk = ~clk;

  audio_tone_scheduler #(
    .TONE_HALF    (4),
    .BEEP_LEN     (40),
    .WAKE_LEN     (8),
    .ALARM_HALF_A (3),
    .ALARM_HALF_B (6),
    .ALARM_SWITCH (24),
    .BEEP_LEVEL   (10'd512)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .beat_pulse    (beat_pulse),
    .alarm_req     (alarm_req),
    .pass_en       (pass_en),
    .adc_measure   (adc_measure),
    .adc_valid     (adc_valid),
    .duty_cycle    (duty_cycle),
    .output_enable (output_enable),
    .pwm_sd        (pwm_sd),
    .busy          (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_duty(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_duty({tag, "_duty"}, duty_cycle, 10'd0);
    check_bit({tag, "_oe"}, output_enable, 1'b0);
    check_bit({tag, "_sd"}, pwm_sd, 1'b0);
    check_bit({tag, "_busy"}, busy, 1'b0);
  endtask

  // k-th cycle of a beep (k from 1): 512 for 4 cycles, 0 for 4 cycles, repeating.
  function automatic logic [9:0] beep_duty(input int k);
    return ((((k - 1) / 4) % 2) == 0) ? 10'd512 : 10'd0;
  endfunction

  // Pulse a beat from IDLE and check the 8-cycle wake interval.
  task automatic beat_and_wake(input string tag);
    beat_pulse = 1'b1;
    step();
    beat_pulse = 1'b0;
    check_bit({tag, "_sd_lat"}, pwm_sd, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step();
      check_bit({tag, "_wake_sd"}, pwm_sd, 1'b1);
      check_bit({tag, "_wake_oe"}, output_enable, 1'b0);
    end
  endtask

  task automatic single_beep(input string tag);
    beat_and_wake(tag);
    for (int k = 1; k <= 40; k++) begin
      step();
      check_bit({tag, "_oe"}, output_enable, 1'b1);
      check_duty({tag, "_duty"}, duty_cycle, beep_duty(k));
    end
    step();
    check_idle({tag, "_end"});
    $display("single beep (%s) done", tag);
  endtask

  initial begin
    step();
    step();
    check_idle("reset");
    reset = 1'b0;
    step();
    check_idle("idle");
    $display("reset state checked");

    single_beep("beep");

    // Retrigger on the 30th beep cycle: beep extends 40 cycles past it, phase unbroken.
    beat_and_wake("retrig");
    for (int k = 1; k <= 70; k++) begin
      beat_pulse = (k == 30);
      step();
      beat_pulse = 1'b0;
      check_bit("retrig_oe", output_enable, 1'b1);
      check_duty("retrig_duty", duty_cycle, beep_duty(k));
    end
    step();
    check_idle("retrig_end");
    $display("beep retrigger done");

`ifdef AUDIO_ALARM_EN
    pos = 0;
    cur = 1'b1;
    alarm_lvl = '0;
    for (int r = 0; r < 14; r++) begin
      for (int j = 0; j < runs[r]; j++) begin
        alarm_lvl[pos] = cur;
        pos++;
      end
      cur = ~cur;
    end
    alarm_req = 1'b1;
    step();
    check_bit("alarm_sd_lat", pwm_sd, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step();
      check_bit("alarm_wake_sd", pwm_sd, 1'b1);
      check_bit("alarm_wake_oe", output_enable, 1'b0);
    end
    for (int k = 1; k <= 54; k++) begin
      alarm_req = (k <= 51);
      step();
      check_bit("alarm_oe", output_enable, 1'b1);
      check_duty("alarm_duty", duty_cycle, alarm_lvl[k-1] ? 10'd512 : 10'd0);
    end
    alarm_req = 1'b0;
    step();
    check_idle("alarm_end");
    $display("alarm tone done");
`else
    alarm_req = 1'b1;
    single_beep("noalarm");
    alarm_req = 1'b0;
`endif

    // Passthrough, with strobes during wake ignored and a beep inserted mid-stream.
    pass_en = 1'b1;
    step();
    check_bit("pass_busy_lat", busy, 1'b0);
    adc_valid = 1'b1;
    adc_measure = 10'h3C3;
    for (int i = 1; i <= 8; i++) begin
      step();
      check_bit("pass_wake_oe", output_enable, 1'b0);
      check_duty("pass_wake_duty", duty_cycle, 10'd0);
    end
    adc_valid = 1'b0;
    step();
    check_bit("pass_oe", output_enable, 1'b1);
    check_duty("pass_ignore_wake_adc", duty_cycle, 10'd0);
    adc_valid = 1'b1;
    adc_measure = 10'h155;
    step();
    adc_valid = 1'b0;
    adc_measure = 10'h3FF;
    check_duty("pass_155", duty_cycle, 10'h155);
    step();
    check_duty("pass_155_hold", duty_cycle, 10'h155);
    adc_valid = 1'b1;
    adc_measure = 10'h2AA;
    step();
    adc_valid = 1'b0;
    adc_measure = 10'h3FF;
    check_duty("pass_2aa", duty_cycle, 10'h2AA);
    step();
    check_duty("pass_2aa_hold", duty_cycle, 10'h2AA);
    beat_pulse = 1'b1;
    step();
    beat_pulse = 1'b0;
    check_duty("pass_beat_edge", duty_cycle, 10'h2AA);
    for (int k = 1; k <= 40; k++) begin
      step();
      check_bit("pass_beep_oe", output_enable, 1'b1);
      check_duty("pass_beep_duty", duty_cycle, beep_duty(k));
    end
    step();
    check_bit("pass_resume_oe", output_enable, 1'b1);
    check_duty("pass_resume_duty", duty_cycle, 10'h2AA);
    adc_valid = 1'b1;
    adc_measure = 10'h0F0;
    step();
    adc_valid = 1'b0;
    check_duty("pass_0f0", duty_cycle, 10'h0F0);
    pass_en = 1'b0;
    step();
    check_bit("pass_last_oe", output_enable, 1'b1);
    step();
    check_idle("pass_end");
    $display("passthrough done");

    // Reset in the middle of a beep.
    beat_and_wake("rstbeep");
    for (int k = 1; k <= 15; k++) step();
    check_bit("rstbeep_pre_oe", output_enable, 1'b1);
    reset = 1'b1;
    step();
    check_idle("rstbeep");
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      check_bit("rstbeep_after_busy", busy, 1'b0);
    end
    $display("reset mid-beep done");

    // Reset in the middle of wake: the latched beat must not survive.
    beat_pulse = 1'b1;
    step();
    beat_pulse = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_bit("rstwake_pre_sd", pwm_sd, 1'b1);
    reset = 1'b1;
    step();
    check_idle("rstwake");
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      check_bit("rstwake_after_sd", pwm_sd, 1'b0);
    end
    $display("reset mid-wake done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
